// File: rtl/ifft_4_point.sv
// ----------------------------------------------------------------------------
// ifft_4_point
//   Four-point inverse FFT. Accepts one complex spectrum frame X[0..3] and
//   returns the time-domain samples x[0..3] scaled by 1/4 (floor rounding).
//   Two radix-2 butterfly stages with trivial twiddles (+-1, +-j), so the
//   datapath is adders only. Valid/ready handshakes on both sides; one frame
//   in flight at a time (IDLE -> STAGE1 -> STAGE2 -> OUTPUT -> IDLE).
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   input_valid   input frame present
//   input_ready   block can accept a frame (high only in IDLE)
//   input_real    X[k].re, bin k in bits [(k+1)*input_size-1 : k*input_size]
//   input_imag    X[k].im, same packing
//   output_valid  output frame present (high only in OUTPUT)
//   output_ready  downstream accepts the frame
//   output_real   x[n].re, same packing by n
//   output_imag   x[n].im, same packing by n
// ----------------------------------------------------------------------------
module ifft_4_point #(
    parameter int input_size       = 16,
    parameter int calculation_size = 18
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [4*input_size-1:0] input_real,
    input  logic [4*input_size-1:0] input_imag,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [4*input_size-1:0] output_real,
    output logic [4*input_size-1:0] output_imag
);

    // Four input_size terms summed need input_size+2 bits to be exact.
    generate
        if (calculation_size < input_size + 2) begin : g_width_check
            $error("ifft_4_point: calculation_size must be at least input_size+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        STAGE1,
        STAGE2,
        OUTPUT
    } state_t;

    typedef logic signed [input_size-1:0]       samp_t;
    typedef logic signed [calculation_size-1:0] calc_t;

    state_t state_q, state_d;

    samp_t x_re_q [4];
    samp_t x_re_d [4];
    samp_t x_im_q [4];
    samp_t x_im_d [4];

    calc_t a_re_q [4];
    calc_t a_re_d [4];
    calc_t a_im_q [4];
    calc_t a_im_d [4];

    calc_t xe_re [4];
    calc_t xe_im [4];
    calc_t s_re  [4];
    calc_t s_im  [4];

    logic [4*input_size-1:0] out_re_q, out_re_d;
    logic [4*input_size-1:0] out_im_q, out_im_d;

    logic in_fire;
    logic out_fire;
    logic unused_s;

    function automatic calc_t sext(input samp_t v);
        return {{(calculation_size-input_size){v[input_size-1]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            out_re_q <= '0;
            out_im_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                x_re_q[k] <= '0;
                x_im_q[k] <= '0;
                a_re_q[k] <= '0;
                a_im_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
            for (int unsigned k = 0; k < 4; k++) begin
                x_re_q[k] <= x_re_d[k];
                x_im_q[k] <= x_im_d[k];
                a_re_q[k] <= a_re_d[k];
                a_im_q[k] <= a_im_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire)  state_d = STAGE1;
            STAGE1:  state_d = STAGE2;
            STAGE2:  state_d = OUTPUT;
            OUTPUT:  if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs, decoded from state only
    // ------------------------------------------------------------------
    always_comb begin
        input_ready  = (state_q == IDLE);
        output_valid = (state_q == OUTPUT);
        output_real  = out_re_q;
        output_imag  = out_im_q;
    end

    assign in_fire  = input_valid & input_ready;
    assign out_fire = output_valid & output_ready;

    // ------------------------------------------------------------------
    // Butterfly arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            xe_re[k] = sext(x_re_q[k]);
            xe_im[k] = sext(x_im_q[k]);
        end
    end

    // Second stage: s1 = a1 + j*a3, s3 = a1 - j*a3 (inverse-direction twiddle).
    always_comb begin
        s_re[0] = a_re_q[0] + a_re_q[2];
        s_im[0] = a_im_q[0] + a_im_q[2];
        s_re[2] = a_re_q[0] - a_re_q[2];
        s_im[2] = a_im_q[0] - a_im_q[2];
        s_re[1] = a_re_q[1] - a_im_q[3];
        s_im[1] = a_im_q[1] + a_re_q[3];
        s_re[3] = a_re_q[1] + a_im_q[3];
        s_im[3] = a_im_q[1] - a_re_q[3];
    end

    // The /4 slice below discards the two LSBs (and any headroom bits).
    assign unused_s = ^{s_re[0], s_re[1], s_re[2], s_re[3],
                        s_im[0], s_im[1], s_im[2], s_im[3]};

    // ------------------------------------------------------------------
    // Datapath next-state: capture, stage 1, stage 2
    // ------------------------------------------------------------------
    always_comb begin
        x_re_d   = x_re_q;
        x_im_d   = x_im_q;
        a_re_d   = a_re_q;
        a_im_d   = a_im_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        x_re_d[k] = input_real[k*input_size +: input_size];
                        x_im_d[k] = input_imag[k*input_size +: input_size];
                    end
                end
            end
            STAGE1: begin
                a_re_d[0] = xe_re[0] + xe_re[2];
                a_im_d[0] = xe_im[0] + xe_im[2];
                a_re_d[1] = xe_re[0] - xe_re[2];
                a_im_d[1] = xe_im[0] - xe_im[2];
                a_re_d[2] = xe_re[1] + xe_re[3];
                a_im_d[2] = xe_im[1] + xe_im[3];
                a_re_d[3] = xe_re[1] - xe_re[3];
                a_im_d[3] = xe_im[1] - xe_im[3];
            end
            STAGE2: begin
                // Taking bits [input_size+1:2] of a two's-complement sum is an
                // arithmetic shift by 2, i.e. floor division by 4.
                for (int unsigned k = 0; k < 4; k++) begin
                    out_re_d[k*input_size +: input_size] = s_re[k][input_size+1:2];
                    out_im_d[k*input_size +: input_size] = s_im[k][input_size+1:2];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ifft_4_point.md
Name: ifft_4_point

Overview:
Inverse counterpart of the 4-point forward FFT unit. It accepts one complex 4-bin spectrum frame and returns the 4 complex time-domain samples scaled by 1/4. Processing uses two radix-2 butterfly stages with trivial twiddles (±1, ±j), so no multipliers are needed. It sits on the synthesis path after spectral processing and before the sample output path, with valid/ready handshakes on both sides.

Parameters:
input_size, 16, bit width of each signed real or imaginary component, at input and at output.
calculation_size, 18, signed internal butterfly width. Must be at least input_size+2; a smaller value is an elaboration error.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
input_valid  input  1  input frame present.
input_ready  output  1  block can accept a frame.
input_real  input  4*input_size  signed X[k].re; bin k in bits [(k+1)*input_size-1 : k*input_size].
input_imag  input  4*input_size  signed X[k].im, same packing.
output_valid  output  1  output frame present.
output_ready  input  1  downstream accepts the frame.
output_real  output  4*input_size  signed x[n].re, same packing by n.
output_imag  output  4*input_size  signed x[n].im, same packing by n.

Behaviour:
- Reset (asynchronous, overrides everything):
  - state = IDLE, input_ready = 1, output_valid = 0.
  - output_real, output_imag and all internal registers = 0.
- States: IDLE -> STAGE1 -> STAGE2 -> OUTPUT -> IDLE.
- IDLE:
  - input_ready = 1.
  - On input_valid & input_ready at an edge, capture input_real/input_imag and go to STAGE1.
- STAGE1 (one cycle), sign-extended to calculation_size:
  - a0 = X0+X2, a1 = X0-X2, a2 = X1+X3, a3 = X1-X3 (complex).
  - Register the results and go to STAGE2.
- STAGE2 (one cycle):
  - s0 = a0+a2, s2 = a0-a2.
  - s1 = a1 + j·a3, i.e. re = a1.re - a3.im, im = a1.im + a3.re.
  - s3 = a1 - j·a3, i.e. re = a1.re + a3.im, im = a1.im - a3.re.
  - Each output component = arithmetic shift right by 2 (floor division by 4) of the sum, taken as bits [input_size+1:2].
  - Register the outputs, set output_valid = 1, go to OUTPUT.
- Width rule: each component is a sum of 4 input_size terms, range ±(2^(input_size+1)-2). After floor/4 it always fits input_size, so no saturation or overflow logic is needed. Rounding is floor, not truncate-toward-zero; for example a sum of -1 gives -1.
- OUTPUT:
  - output_valid = 1, input_ready = 0.
  - output_real/output_imag are held stable while output_ready = 0.
  - On output_valid & output_ready at an edge, go to IDLE: output_valid = 0 and input_ready = 1 the next cycle. Output data keeps its last value.
- Latency: handshake at edge E0 -> output_valid high after edge E2.
- Throughput: with output_ready tied high, one frame per 4 cycles.
- input_valid while not in IDLE: ignored (input_ready = 0). Input data does not need to be held after capture.
- output_ready while output_valid = 0: ignored.
- input_ready and output_valid are never both 1.
- Reset mid-operation (any state): the frame is discarded, reset values apply, and the next frame after reset release is processed normally.

Test Plan:
- DC: X0 = (400,0), other bins 0 -> all x[n] = (100,0), output_valid after 2 edges.
- Single bin: X1 = (400,0), others 0 -> x0 = (100,0), x1 = (0,100), x2 = (-100,0), x3 = (0,-100).
- Extremes, input_size = 16:
  - X0.re = 32767, X2.re = -32768, X1.im = -32768, X3.im = 32767, rest 0 -> x1.re = 32767, no wrap.
  - Negated pattern (X0.re = -32768, X2.re = 32767, X1.im = 32767, X3.im = -32768) -> x1.re = -32768.
  - X0 = (-1,0) alone -> all x[n].re = -1 (floor rounding).
- Backpressure: output_ready low for 5 cycles with input_valid high and new data -> output held bit-exact, input_ready = 0, second frame not captured. After output_ready rises, first frame completes, then the second frame is accepted.
- Reset asserted during STAGE2 -> output_valid = 0 and outputs = 0 immediately, input_ready = 1 after release. The next DC frame gives the correct result.
- Streaming: input_valid and output_ready held high with 8 random frames -> accepted every 4 cycles, all outputs match a floor(sum/4) reference model.
